// File: rtl/apb_master.sv
// APB master: turns single valid/ready commands into APB SETUP/ACCESS
// transfers and returns a one-cycle response pulse per accepted command.
//
// Ports
//   PCLK, PRESETn                  clock, asynchronous active-low reset
//   cmd_valid / cmd_ready          command handshake (accept on both high)
//   cmd_write, cmd_addr,
//   cmd_wdata, cmd_strb            command payload
//   rsp_valid                      one-cycle completion pulse
//   rsp_rdata, rsp_timeout         read data / abort flag, valid with rsp_valid
//   PSELx, PENABLE, PWRITE,
//   PADDR, PSTRB, PWDATA           APB request outputs (all registered)
//   PRDATA, PREADY                 APB completer response inputs
module apb_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int NBYTES         = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [NBYTES-1:0]     cmd_strb,

    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_timeout,

    output logic                  PSELx,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [NBYTES-1:0]     PSTRB,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    // Wait counter is 8 bits wide; the limit is folded to the same width.
    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

    state_e                state_q,       state_d;
    logic [7:0]            wait_cnt_q,    wait_cnt_d;
    logic                  cmd_ready_q,   cmd_ready_d;
    logic                  psel_q,        psel_d;
    logic                  penable_q,     penable_d;
    logic                  pwrite_q,      pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q,       paddr_d;
    logic [NBYTES-1:0]     pstrb_q,       pstrb_d;
    logic [DATA_WIDTH-1:0] pwdata_q,      pwdata_d;
    logic                  rsp_valid_q,   rsp_valid_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q,   rsp_rdata_d;

    logic                  accept;
    logic                  at_limit;

    // cmd_ready comes from a flop, so the handshake never depends
    // combinationally on cmd_valid.
    assign accept   = cmd_valid && cmd_ready_q;
    assign at_limit = (wait_cnt_q == TIMEOUT_LIM);

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        cmd_ready_d   = cmd_ready_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pstrb_d       = pstrb_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = 1'b0;
        rsp_timeout_d = 1'b0;
        rsp_rdata_d   = '0;

        unique case (state_q)
            IDLE: begin
                // Ready rises on the first edge after reset release.
                cmd_ready_d = 1'b1;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
                if (accept) begin
                    state_d     = SETUP;
                    cmd_ready_d = 1'b0;
                    psel_d      = 1'b1;
                    wait_cnt_d  = '0;
                    pwrite_d    = cmd_write;
                    paddr_d     = cmd_addr;
                    // Reads never present stale write data or strobes.
                    pstrb_d     = cmd_write ? cmd_strb  : '0;
                    pwdata_d    = cmd_write ? cmd_wdata : '0;
                end
            end

            SETUP: begin
                state_d   = ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end

            ACCESS: begin
                if (PREADY) begin
                    // PREADY wins over a coincident timeout.
                    state_d     = IDLE;
                    cmd_ready_d = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                end else if (at_limit) begin
                    state_d       = IDLE;
                    cmd_ready_d   = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b0;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= IDLE;
            wait_cnt_q    <= '0;
            cmd_ready_q   <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pstrb_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pstrb_q       <= pstrb_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_rdata_q   <= rsp_rdata_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_timeout = rsp_timeout_q;
    assign PSELx       = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PSTRB       = pstrb_q;
    assign PWDATA      = pwdata_q;

endmodule
